// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Sits between the EX/MEM pipeline stage and data_memory. It takes one
// memory request at a time over a valid/ready handshake and turns it into
// data_memory accesses that use data_memory's own we/re encodings.
//
// Aligned requests go out as a single native access. Misaligned halfword and
// word requests become a run of byte accesses (sb for stores, lbu for loads).
// For loads, the returned bytes are reassembled little-endian and then sign-
// or zero-extended. Every load or store produces one rsp_valid pulse.
//
// Parameters
//   SPLIT_EN   1: split misaligned accesses into byte accesses
//              0: misaligned accesses return rsp_err and touch no memory
//
// Ports
//   clk, reset                clock and asynchronous active-high reset
//   req_valid / req_ready     request handshake (ready only in IDLE, out of reset)
//   req_addr, req_wdata       byte address and right-aligned store data
//   req_we                    0 none, 1 sb, 2 sh, 3 sw
//   req_re                    0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu (6/7 illegal)
//   rsp_valid                 one-cycle completion pulse, no backpressure
//   rsp_rdata                 extended load result; 0 for stores and errors
//   rsp_err                   marks an illegal or disallowed request
//   mem_addr/wdata/we/re      registered drive to data_memory
//   mem_rdata                 data_memory read data (combinational)
module load_store_unit #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_re,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_we,
  output logic [2:0]  mem_re,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  we_q, we_d;
  logic [2:0]  re_q, re_d;
  logic [31:0] asm_q, asm_d;

  logic        rspValid_q, rspValid_d;
  logic        rspErr_q, rspErr_d;
  logic [31:0] rspRdata_q, rspRdata_d;

  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [1:0]  memWe_q, memWe_d;
  logic [2:0]  memRe_q, memRe_d;

  logic [1:0]  reqLast;
  logic [1:0]  curLast;
  logic        misaligned;
  logic        illegal;
  logic [31:0] asmNext;

  // Index of the last byte of an access (size minus one): 0 byte, 1 half, 3 word.
  function automatic logic [1:0] lastIdx(input logic [1:0] we, input logic [2:0] re);
    logic [1:0] idx;
    idx = 2'd0;
    if (we == 2'd2 || re == 3'd2 || re == 3'd5) begin
      idx = 2'd1;
    end else if (we == 2'd3 || re == 3'd3) begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Final extension of a byte-assembled load. Only lh, lhu and lw can be
  // misaligned, so bytes never reach this path.
  function automatic logic [31:0] extendLoad(input logic [31:0] a, input logic [2:0] re);
    logic [31:0] r;
    case (re)
      3'd2:    r = {{16{a[15]}}, a[15:0]};
      3'd5:    r = {16'h0000, a[15:0]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Ready is gated with reset so it drops the instant reset asserts.
  assign req_ready = (state_q == IDLE) && !reset;

  assign rsp_valid = rspValid_q;
  assign rsp_err   = rspErr_q;
  assign rsp_rdata = rspRdata_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_we    = memWe_q;
  assign mem_re    = memRe_q;

  // Next-state logic. IDLE classifies a newly accepted request: empty
  // requests are dropped, illegal ones answer with an error next cycle, and
  // legal ones go to ACCESS (aligned) or SPLIT (misaligned byte loop).
  // The mem_* drive is computed from the next state, so the registered
  // outputs line up with the cycle in which the access takes place.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    re_d       = re_q;
    asm_d      = asm_q;
    rspValid_d = 1'b0;
    rspErr_d   = 1'b0;
    rspRdata_d = 32'h0;
    reqLast    = lastIdx(req_we, req_re);
    curLast    = lastIdx(we_q, re_q);
    misaligned = 1'b0;
    illegal    = 1'b0;
    asmNext    = asm_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          re_d    = req_re;
          k_d     = 2'd0;
          asm_d   = 32'h0;
          misaligned = (reqLast == 2'd1 && req_addr[0]) ||
                       (reqLast == 2'd3 && req_addr[1:0] != 2'b00);
          illegal = (req_we != 2'd0 && req_re != 3'd0) || (req_re >= 3'd6) ||
                    (misaligned && !SPLIT_EN);
          if (req_we != 2'd0 || req_re != 3'd0) begin
            if (illegal) begin
              rspValid_d = 1'b1;
              rspErr_d   = 1'b1;
            end else if (misaligned) begin
              state_d = SPLIT;
            end else begin
              state_d = ACCESS;
            end
          end
        end
      end

      ACCESS: begin
        state_d    = IDLE;
        rspValid_d = 1'b1;
        if (re_q != 3'd0) begin
          rspRdata_d = mem_rdata;
        end
      end

      SPLIT: begin
        if (re_q != 3'd0) begin
          asmNext[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
        end
        asm_d = asmNext;
        if (k_q == curLast) begin
          state_d    = IDLE;
          k_d        = 2'd0;
          rspValid_d = 1'b1;
          if (re_q != 3'd0) begin
            rspRdata_d = extendLoad(asmNext, re_q);
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
        k_d     = 2'd0;
      end
    endcase

    memAddr_d  = 32'h0;
    memWdata_d = 32'h0;
    memWe_d    = 2'd0;
    memRe_d    = 3'd0;
    if (state_d == ACCESS) begin
      memAddr_d  = addr_d;
      memWdata_d = wdata_d;
      memWe_d    = we_d;
      memRe_d    = re_d;
    end else if (state_d == SPLIT) begin
      memAddr_d = addr_d + {30'h0, k_d};
      if (we_d != 2'd0) begin
        memWe_d    = 2'd1;
        memWdata_d = {24'h0, wdata_d[{k_d, 3'b000} +: 8]};
      end else begin
        memRe_d = 3'd4;
      end
    end
  end

  // State and output registers. Reset clears everything asynchronously, so
  // an in-flight access stops driving memory at once and its response is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 2'd0;
      re_q       <= 3'd0;
      asm_q      <= 32'h0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= 32'h0;
      memAddr_q  <= 32'h0;
      memWdata_q <= 32'h0;
      memWe_q    <= 2'd0;
      memRe_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      asm_q      <= asm_d;
      rspValid_q <= rspValid_d;
      rspErr_q   <= rspErr_d;
      rspRdata_q <= rspRdata_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      memRe_q    <= memRe_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a byte-array data_memory model, a table of
// directed requests with hand-computed results, and hand-written sequences
// for back-to-back issue, the no-split configuration and reset mid-request.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_we;
  logic [2:0]  req_re;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_we;
  logic [2:0]  mem_re;
  logic [31:0] mem_rdata;

  logic        nsValid;
  logic        nsReady;
  logic [31:0] nsAddr;
  logic [31:0] nsWdata;
  logic [1:0]  nsWe;
  logic [2:0]  nsRe;
  logic        nsRspValid;
  logic [31:0] nsRdata;
  logic        nsErr;
  logic [31:0] nsMemAddr;
  logic [31:0] nsMemWdata;
  logic [1:0]  nsMemWe;
  logic [2:0]  nsMemRe;
  logic [31:0] nsMemRdata;

  bit [7:0] memArr [256];

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [1:0]  we;
    logic [2:0]  re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expAcc;
    logic [1:0]  expWe;
    logic [2:0]  expRe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs [20];

  always #5 clk = ~clk;

  assign nsMemRdata = 32'h0;

  load_store_unit #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.SPLIT_EN(1'b0)) dutNs (
    .clk(clk), .reset(reset),
    .req_valid(nsValid), .req_ready(nsReady),
    .req_addr(nsAddr), .req_wdata(nsWdata), .req_we(nsWe), .req_re(nsRe),
    .rsp_valid(nsRspValid), .rsp_rdata(nsRdata), .rsp_err(nsErr),
    .mem_addr(nsMemAddr), .mem_wdata(nsMemWdata), .mem_we(nsMemWe), .mem_re(nsMemRe),
    .mem_rdata(nsMemRdata)
  );

  // data_memory read side: combinational, little-endian, 256-byte wrap.
  always_comb begin
    mem_rdata = 32'h0;
    case (mem_re)
      3'd1: mem_rdata = {{24{memArr[mem_addr[7:0]][7]}}, memArr[mem_addr[7:0]]};
      3'd2: mem_rdata = {{16{memArr[mem_addr[7:0] + 8'd1][7]}},
                         memArr[mem_addr[7:0] + 8'd1], memArr[mem_addr[7:0]]};
      3'd3: mem_rdata = {memArr[mem_addr[7:0] + 8'd3], memArr[mem_addr[7:0] + 8'd2],
                         memArr[mem_addr[7:0] + 8'd1], memArr[mem_addr[7:0]]};
      3'd4: mem_rdata = {24'h0, memArr[mem_addr[7:0]]};
      3'd5: mem_rdata = {16'h0, memArr[mem_addr[7:0] + 8'd1], memArr[mem_addr[7:0]]};
      default: mem_rdata = 32'h0;
    endcase
  end

  // data_memory write side: sb/sh/sw on the rising edge.
  always @(posedge clk) begin
    case (mem_we)
      2'd1: memArr[mem_addr[7:0]] <= mem_wdata[7:0];
      2'd2: begin
        memArr[mem_addr[7:0]]        <= mem_wdata[7:0];
        memArr[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      end
      2'd3: begin
        memArr[mem_addr[7:0]]        <= mem_wdata[7:0];
        memArr[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
        memArr[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        memArr[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
      default: ;
    endcase
  end

  function automatic vec_t mkVec(
    input logic [1:0] we, input logic [2:0] re, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr,
    input int expLat, input int expAcc, input logic [1:0] expWe,
    input logic [2:0] expRe, input logic [31:0] expAddr, input logic [31:0] expWdata);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat; v.expAcc = expAcc;
    v.expWe = expWe; v.expRe = expRe; v.expAddr = expAddr; v.expWdata = expWdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, then watch memory activity and the response.
  // expLat == 0 means no response is expected at all.
  task automatic applyStimulus(input vec_t v, input int id);
    int          lat;
    int          acc;
    logic [1:0]  fWe;
    logic [2:0]  fRe;
    logic [31:0] fAddr;
    logic [31:0] fWdata;
    logic [31:0] rdata;
    logic        err;
    logic        readyAtRsp;
    lat = 0; acc = 0; fWe = 2'd0; fRe = 3'd0; fAddr = 32'h0; fWdata = 32'h0;
    rdata = 32'h0; err = 1'b0; readyAtRsp = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("v%0d ready", id), {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = v.we; req_re = v.re; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 2'd0; req_re = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we != 2'd0 || mem_re != 3'd0) begin
        if (acc == 0) begin
          fWe = mem_we; fRe = mem_re; fAddr = mem_addr; fWdata = mem_wdata;
        end
        acc++;
      end
      if (rsp_valid) begin
        lat = c; rdata = rsp_rdata; err = rsp_err; readyAtRsp = req_ready;
        break;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d latency", id), lat, v.expLat);
    checkOutput($sformatf("v%0d accesses", id), acc, v.expAcc);
    checkOutput($sformatf("v%0d mem_we", id), {30'h0, fWe}, {30'h0, v.expWe});
    checkOutput($sformatf("v%0d mem_re", id), {29'h0, fRe}, {29'h0, v.expRe});
    checkOutput($sformatf("v%0d mem_addr", id), fAddr, v.expAddr);
    checkOutput($sformatf("v%0d mem_wdata", id), fWdata, v.expWdata);
    if (v.expLat != 0) begin
      checkOutput($sformatf("v%0d rdata", id), rdata, v.expRdata);
      checkOutput($sformatf("v%0d err", id), {31'h0, err}, {31'h0, v.expErr});
      checkOutput($sformatf("v%0d ready at rsp", id), {31'h0, readyAtRsp}, 32'h1);
    end
  endtask

  initial begin
    int pulses;
    //                 we re  addr          wdata         expRdata      err lat acc eWe eRe eAddr         eWdata
    vecs[0]  = mkVec(3, 0, 32'd32,       32'h8000c0fe, 32'h0,        0, 2, 1, 3, 0, 32'd32,       32'h8000c0fe);
    vecs[1]  = mkVec(0, 3, 32'd32,       32'h0,        32'h8000c0fe, 0, 2, 1, 0, 3, 32'd32,       32'h0);
    vecs[2]  = mkVec(3, 0, 32'd10,       32'h8000c0fe, 32'h0,        0, 5, 4, 1, 0, 32'd10,       32'hfe);
    vecs[3]  = mkVec(0, 3, 32'd10,       32'h0,        32'h8000c0fe, 0, 5, 4, 0, 4, 32'd10,       32'h0);
    vecs[4]  = mkVec(0, 2, 32'd11,       32'h0,        32'h000000c0, 0, 3, 2, 0, 4, 32'd11,       32'h0);
    vecs[5]  = mkVec(0, 1, 32'd13,       32'h0,        32'hffffff80, 0, 2, 1, 0, 1, 32'd13,       32'h0);
    vecs[6]  = mkVec(0, 5, 32'd12,       32'h0,        32'h00008000, 0, 2, 1, 0, 5, 32'd12,       32'h0);
    vecs[7]  = mkVec(0, 2, 32'd12,       32'h0,        32'hffff8000, 0, 2, 1, 0, 2, 32'd12,       32'h0);
    vecs[8]  = mkVec(0, 6, 32'd20,       32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h0);
    vecs[9]  = mkVec(1, 1, 32'd20,       32'hff,       32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h0);
    vecs[10] = mkVec(0, 0, 32'd5,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0);
    vecs[11] = mkVec(2, 0, 32'd31,       32'h0000abcd, 32'h0,        0, 3, 2, 1, 0, 32'd31,       32'hcd);
    vecs[12] = mkVec(0, 5, 32'd31,       32'h0,        32'h0000abcd, 0, 3, 2, 0, 4, 32'd31,       32'h0);
    vecs[13] = mkVec(0, 2, 32'd31,       32'h0,        32'hffffabcd, 0, 3, 2, 0, 4, 32'd31,       32'h0);
    vecs[14] = mkVec(0, 3, 32'd32,       32'h0,        32'h8000c0ab, 0, 2, 1, 0, 3, 32'd32,       32'h0);
    vecs[15] = mkVec(1, 0, 32'hffffffff, 32'h12,       32'h0,        0, 2, 1, 1, 0, 32'hffffffff, 32'h12);
    vecs[16] = mkVec(3, 0, 32'd0,        32'h00785634, 32'h0,        0, 2, 1, 3, 0, 32'd0,        32'h00785634);
    vecs[17] = mkVec(0, 3, 32'hffffffff, 32'h0,        32'h78563412, 0, 5, 4, 0, 4, 32'hffffffff, 32'h0);
    vecs[18] = mkVec(0, 7, 32'd0,        32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h0);
    vecs[19] = mkVec(0, 4, 32'd13,       32'h0,        32'h00000080, 0, 2, 1, 0, 4, 32'd13,       32'h0);

    reset = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_we = 2'd0; req_re = 3'd0;
    nsValid = 1'b0; nsAddr = 32'h0; nsWdata = 32'h0; nsWe = 2'd0; nsRe = 3'd0;
    #2;
    checkOutput("reset ready", {31'h0, req_ready}, 32'h0);
    checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset mem_we", {30'h0, mem_we}, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("ready after reset", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Back-to-back: a second request accepted in the response cycle of the first.
    @(negedge clk);
    req_valid = 1'b1; req_re = 3'd3; req_addr = 32'd32;
    @(negedge clk);
    req_valid = 1'b0; req_re = 3'd0; req_addr = 32'h0;
    @(negedge clk);
    checkOutput("b2b rsp1 valid", {31'h0, rsp_valid}, 32'h1);
    checkOutput("b2b rsp1 rdata", rsp_rdata, 32'h8000c0ab);
    checkOutput("b2b ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_re = 3'd4; req_addr = 32'hffffffff;
    @(negedge clk);
    req_valid = 1'b0; req_re = 3'd0; req_addr = 32'h0;
    checkOutput("b2b mem_re", {29'h0, mem_re}, 32'h4);
    checkOutput("b2b mem_addr", mem_addr, 32'hffffffff);
    @(negedge clk);
    checkOutput("b2b rsp2 valid", {31'h0, rsp_valid}, 32'h1);
    checkOutput("b2b rsp2 rdata", rsp_rdata, 32'h00000012);

    // No-split instance: misaligned lw and an illegal opcode both error out.
    @(negedge clk);
    nsValid = 1'b1; nsRe = 3'd3; nsAddr = 32'd10;
    @(negedge clk);
    nsValid = 1'b0; nsRe = 3'd0; nsAddr = 32'h0;
    checkOutput("ns lw10 mem_re", {29'h0, nsMemRe}, 32'h0);
    checkOutput("ns lw10 valid", {31'h0, nsRspValid}, 32'h1);
    checkOutput("ns lw10 err", {31'h0, nsErr}, 32'h1);
    checkOutput("ns lw10 rdata", nsRdata, 32'h0);
    @(negedge clk);
    checkOutput("ns lw10 pulse end", {31'h0, nsRspValid}, 32'h0);
    nsValid = 1'b1; nsRe = 3'd6; nsAddr = 32'd8;
    @(negedge clk);
    nsValid = 1'b0; nsRe = 3'd0; nsAddr = 32'h0;
    checkOutput("ns re6 valid", {31'h0, nsRspValid}, 32'h1);
    checkOutput("ns re6 err", {31'h0, nsErr}, 32'h1);
    @(negedge clk);
    nsValid = 1'b1; nsRe = 3'd3; nsAddr = 32'd32;
    @(negedge clk);
    nsValid = 1'b0; nsRe = 3'd0; nsAddr = 32'h0;
    checkOutput("ns aligned mem_re", {29'h0, nsMemRe}, 32'h3);
    @(negedge clk);
    checkOutput("ns aligned err", {31'h0, nsErr}, 32'h0);

    // Reset after the second sb of a misaligned sw at 10.
    @(negedge clk);
    req_valid = 1'b1; req_we = 2'd3; req_addr = 32'd10; req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("abort pre mem_addr", mem_addr, 32'd12);
    reset = 1'b1;
    #1;
    checkOutput("abort mem_we", {30'h0, mem_we}, 32'h0);
    checkOutput("abort mem_addr", mem_addr, 32'h0);
    checkOutput("abort mem_wdata", mem_wdata, 32'h0);
    checkOutput("abort ready", {31'h0, req_ready}, 32'h0);
    checkOutput("abort rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort ready after", {31'h0, req_ready}, 32'h1);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    checkOutput("abort no rsp", pulses, 0);
    applyStimulus(mkVec(0, 3, 32'd10, 32'h0, 32'h80003344, 0, 5, 4, 0, 4, 32'd10, 32'h0), 100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Absolute time limit so the run always reaches a verdict.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the EX/MEM pipeline stage and `data_memory`. It accepts one memory request at a time over a valid/ready handshake and issues it to `data_memory` using the existing `we`/`re` encodings. Aligned accesses go out as one native access. Misaligned halfword/word accesses are split into sequential byte accesses, and loads are reassembled with sign or zero extension. It returns one response pulse per load or store.

## Interface
- `SPLIT_EN`, default 1: 1 = split misaligned accesses into byte accesses; 0 = misaligned accesses complete with `rsp_err` and touch no memory.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE with `reset` low.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_we` in 2: 0 none, 1 sb, 2 sh, 3 sw.
- `req_re` in 3: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu; 6 and 7 are illegal.
- `rsp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `rsp_rdata` out 32: load result, extended per `req_re`; 0 for stores and errors.
- `rsp_err` out 1: valid with `rsp_valid`; marks an illegal or disallowed request.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_we` out 2, `mem_re` out 3: drive `data_memory`.
- `mem_rdata` in 32: `data_memory` read data, combinational from `mem_addr`/`mem_re`.

## Operation
- States: IDLE, ACCESS (single native access), SPLIT (byte loop with counter k = 0..N-1).
- Request is accepted on the edge where `req_valid && req_ready`; opcode, address and wdata are latched.
- Request classification at accept:
  - `req_we == 0 && req_re == 0`: accepted and dropped, no response, stay in IDLE.
  - Both nonzero, or `req_re` is 6 or 7: error, no memory access.
  - Size N: byte = 1, half = 2, word = 4.
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0. A byte is never misaligned.
  - Misaligned with `SPLIT_EN = 0`: error.
- Error path: go to IDLE; next cycle `rsp_valid = 1`, `rsp_err = 1`, `rsp_rdata = 0`.
- Aligned path: go to ACCESS.
  - Drive `mem_addr` = addr, the native `mem_we`/`mem_re` code, and `mem_wdata` = wdata for one cycle.
  - Capture `mem_rdata` at the closing edge. `data_memory` already applies the extension.
- Misaligned path: go to SPLIT. For each k:
  - `mem_addr` = addr + k, mod 2^32 (the address wraps).
  - Store: `mem_we` = 1 (sb), `mem_wdata` = {24'b0, wdata[8k+7:8k]}.
  - Load: `mem_re` = 4 (lbu); capture byte k into an assembly register, little-endian.
  - After byte N-1, extend per opcode: lh/lw sign-extend from bit 8N-1, lhu zero-extends.
- Whenever no access is in progress: `mem_we = 0`, `mem_re = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- Reset:
  - State returns to IDLE, k = 0.
  - All outputs go to 0 immediately, `req_ready` included.
  - `req_ready` becomes 1 in the first cycle after `reset` deasserts.
- Reset mid-operation: the request is aborted and no response is issued. Bytes already written by earlier sb accesses stay in memory.

## Timing
- Accept edge E0. ACCESS or SPLIT occupies cycles 1..N (N = 1 when aligned).
- The last access ends at edge EN. IDLE is re-entered there, and in cycle N+1 both `rsp_valid` = 1 and `req_ready` = 1.
- Back-to-back operation: a new request can be accepted at the end of the `rsp_valid` cycle.
- Latency from accept to response: 2 cycles aligned, N+1 cycles misaligned, 1 cycle for an error.
- `rsp_*` are registered. `mem_*` are registered or derived from state only; no input-to-`mem_*` combinational path.

## Test plan
- Aligned sw at addr 32, wdata 0x8000c0fe, then lw at addr 32 -> one mem cycle each with `mem_we` = 3 and then `mem_re` = 3; `rsp_valid` 2 cycles after each accept; lw `rsp_rdata` = 0x8000c0fe.
- Misaligned sw at addr 10, wdata 0x8000c0fe -> four sb cycles at addrs 10..13 with `mem_wdata` 0xfe, 0xc0, 0x00, 0x80; rsp in cycle 5. Then lw at 10 -> four lbu cycles, `rsp_rdata` = 0x8000c0fe. Then lh at 11 -> two cycles, `rsp_rdata` = 0x000000c0.
- lb at addr 13 after the misaligned sw -> single access with `mem_re` = 1, `rsp_rdata` = 0xffffff80. lhu at 12 -> aligned, `rsp_rdata` = 0x00008000.
- `SPLIT_EN` = 0, lw at addr 10 -> no `mem_re` activity; next cycle `rsp_err` = 1, `rsp_rdata` = 0. `req_re` = 6 -> same error response.
- Misaligned sw at addr 10; assert `reset` after the 2nd sb -> `mem_we` drops to 0 immediately; no `rsp_valid`; only addrs 10 and 11 are written; `req_ready` = 1 in the first cycle after reset deasserts.
- Misaligned lw at 0xffffffff -> byte accesses at 0xffffffff, 0x0, 0x1, 0x2 (wrap); `rsp_rdata` assembled in that byte order.
